// File: rtl/cus19_pkg.sv
// cus19_pkg: shared state encoding and widths for the Custom-19 branch logic
package cus19_pkg;
  localparam int CUS19_ADDR_WIDTH = 19;
  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_REDIRECT = 2'd1,
    BR_FLUSH    = 2'd2
  } br_state_t;
endpackage

// File: rtl/cus19_sat_counter.sv
// cus19_sat_counter: up-counter that sticks at all-ones
module cus19_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         inc_in,
  output logic [W-1:0] cnt_out
);
  always_ff @(posedge clk_in)
    if (rst_in) cnt_out <= '0;
    else if (inc_in && !(&cnt_out)) cnt_out <= cnt_out + 1'b1;
endmodule

// File: rtl/cus19_branch_ctrl.sv
// cus19_branch_ctrl: IE-stage branch redirect sequencer with squash and statistics
module cus19_branch_ctrl
  import cus19_pkg::*;
#(
  parameter int ADDR_WIDTH   = CUS19_ADDR_WIDTH,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  branch_valid_in,
  input  logic                  jump_in,
  input  logic                  branch_taken_in,
  input  logic [ADDR_WIDTH-1:0] target_in,
  input  logic                  ie_stall_in,
  input  logic                  fetch_ready_in,
  output logic                  redirect_valid_out,
  output logic [ADDR_WIDTH-1:0] redirect_pc_out,
  output logic                  flush_if_out,
  output logic                  flush_id_out,
  output logic                  stall_ie_out,
  output logic [CNT_WIDTH-1:0]  resolved_cnt_out,
  output logic [CNT_WIDTH-1:0]  taken_cnt_out
);
  localparam logic [3:0] FLUSH_LOAD = FLUSH_CYCLES == 0 ? 4'd0 : 4'(FLUSH_CYCLES - 1);
  br_state_t  state_q, state_d;
  logic [3:0] flush_cnt;
  logic       accept, take, busy;
  assign accept = branch_valid_in && !ie_stall_in && state_q == BR_IDLE;
  assign take   = accept && (jump_in || branch_taken_in);
  always_comb begin
    state_d = BR_IDLE;
    state_d = state_q == BR_IDLE ? (take ? BR_REDIRECT : BR_IDLE) :
              state_q == BR_REDIRECT ? (!fetch_ready_in ? BR_REDIRECT :
                                        FLUSH_CYCLES == 0 ? BR_IDLE : BR_FLUSH) :
              (state_q == BR_FLUSH && flush_cnt != 4'd0) ? BR_FLUSH : BR_IDLE;
    busy               = state_q == BR_REDIRECT || state_q == BR_FLUSH;
    redirect_valid_out = state_q == BR_REDIRECT;
    flush_if_out       = busy;
    flush_id_out       = busy;
    stall_ie_out       = busy;
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state_q         <= BR_IDLE;
      flush_cnt       <= 4'd0;
      redirect_pc_out <= '0;
    end else begin
      state_q <= state_d;
      if (take) redirect_pc_out <= target_in;
      if (state_q == BR_REDIRECT && fetch_ready_in) flush_cnt <= FLUSH_LOAD;
      else if (state_q == BR_FLUSH && flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
    end
  cus19_sat_counter #(.W(CNT_WIDTH)) u_resolved (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc_in (accept),
    .cnt_out(resolved_cnt_out)
  );
  cus19_sat_counter #(.W(CNT_WIDTH)) u_taken (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc_in (take),
    .cnt_out(taken_cnt_out)
  );
endmodule

// File: tb/tb_cus19_branch_ctrl.sv
// tb_cus19_branch_ctrl: directed checks of redirect timing, flush, backpressure and counters
module tb_cus19_branch_ctrl;
  logic        clk_in = 0;
  logic        rst_in = 1, valid = 0, jump = 0, taken = 0, ie_stall = 0, ready = 0;
  logic [18:0] target = '0;
  logic        rv, fif, fid, stall;
  logic [18:0] pc;
  logic [15:0] res_cnt, tk_cnt;
  logic        s_rst = 1, s_valid = 0, s_jump = 0, s_ready = 0;
  logic        s_rv, s_fif, s_fid, s_stall;
  logic [18:0] s_pc;
  logic [3:0]  s_res, s_tk;
  int total = 0, bad = 0;

  always #5 clk_in = ~clk_in;

  cus19_branch_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .branch_valid_in(valid), .jump_in(jump),
    .branch_taken_in(taken), .target_in(target), .ie_stall_in(ie_stall),
    .fetch_ready_in(ready), .redirect_valid_out(rv), .redirect_pc_out(pc),
    .flush_if_out(fif), .flush_id_out(fid), .stall_ie_out(stall),
    .resolved_cnt_out(res_cnt), .taken_cnt_out(tk_cnt)
  );

  cus19_branch_ctrl #(.FLUSH_CYCLES(0), .CNT_WIDTH(4)) dut_sat (
    .clk_in(clk_in), .rst_in(s_rst), .branch_valid_in(s_valid), .jump_in(s_jump),
    .branch_taken_in(1'b0), .target_in(19'h00005), .ie_stall_in(1'b0),
    .fetch_ready_in(s_ready), .redirect_valid_out(s_rv), .redirect_pc_out(s_pc),
    .flush_if_out(s_fif), .flush_id_out(s_fid), .stall_ie_out(s_stall),
    .resolved_cnt_out(s_res), .taken_cnt_out(s_tk)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    tick(); tick();
    chk("rst_rv", rv, 0); chk("rst_pc", pc, 0); chk("rst_fif", fif, 0);
    chk("rst_fid", fid, 0); chk("rst_stall", stall, 0);
    chk("rst_res", res_cnt, 0); chk("rst_tk", tk_cnt, 0);
    rst_in = 0;
    // taken branch, fetch ready immediately
    valid = 1; taken = 1; target = 19'h00A40; ready = 1;
    tick();
    valid = 0; taken = 0;
    chk("ber_rv", rv, 1); chk("ber_pc", pc, 19'h00A40); chk("ber_fif", fif, 1);
    chk("ber_stall", stall, 1); chk("ber_res", res_cnt, 1); chk("ber_tk", tk_cnt, 1);
    tick();
    chk("ber_f1_rv", rv, 0); chk("ber_f1_fif", fif, 1); chk("ber_f1_stall", stall, 1);
    tick();
    chk("ber_f2_fid", fid, 1); chk("ber_f2_stall", stall, 1);
    tick();
    chk("ber_idle_stall", stall, 0); chk("ber_idle_fif", fif, 0);
    // not-taken branch
    valid = 1; taken = 0; target = 19'h00123;
    tick();
    valid = 0;
    chk("bne_rv", rv, 0); chk("bne_stall", stall, 0); chk("bne_fif", fif, 0);
    chk("bne_res", res_cnt, 2); chk("bne_tk", tk_cnt, 1);
    // backpressure with an all-ones jump target and a competing branch
    ready = 0; valid = 1; jump = 1; target = 19'h7FFFF;
    tick();
    target = 19'h01234;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rv", rv, 1); chk("bp_pc", pc, 19'h7FFFF); chk("bp_res", res_cnt, 3);
      chk("bp_tk", tk_cnt, 2);
      if (i < 2) tick();
    end
    valid = 0; jump = 0; ready = 1;
    tick();
    chk("bp_flush_rv", rv, 0); chk("bp_flush_fif", fif, 1);
    chk("bp_res_after", res_cnt, 3); chk("bp_pc_after", pc, 19'h7FFFF);
    tick(); tick();
    chk("bp_idle_stall", stall, 0);
    // reset during REDIRECT
    valid = 1; jump = 1; target = 19'h00055; ready = 0;
    tick();
    chk("mid_rv", rv, 1);
    valid = 0; jump = 0; rst_in = 1;
    tick();
    chk("mid_rst_rv", rv, 0); chk("mid_rst_fif", fif, 0); chk("mid_rst_stall", stall, 0);
    chk("mid_rst_res", res_cnt, 0); chk("mid_rst_tk", tk_cnt, 0); chk("mid_rst_pc", pc, 0);
    rst_in = 0; ready = 1;
    // IE stalled: nothing accepted
    valid = 1; jump = 1; ie_stall = 1;
    tick();
    chk("iestall_rv", rv, 0); chk("iestall_res", res_cnt, 0);
    ie_stall = 0; valid = 0;
    // jump without valid is ignored
    tick();
    chk("novalid_rv", rv, 0); chk("novalid_res", res_cnt, 0);
    jump = 0;
    // saturation on narrow counters, one take every two cycles
    s_rst = 0; s_ready = 1; s_valid = 1; s_jump = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid_res", s_res, 5); chk("sat_mid_tk", s_tk, 5);
    for (int i = 0; i < 30; i++) tick();
    chk("sat_res", s_res, 4'hF); chk("sat_tk", s_tk, 4'hF); chk("sat_pc", s_pc, 19'h00005);
    s_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
